// File: rtl/action_repeat_gen.sv
// action_repeat_gen: button to action pulses with DAS/ARR auto-repeat; ACTION_REPEAT_SYNC_EN adds a 2-flop btn synchronizer
module action_repeat_gen #(
    parameter logic [31:0] DAS_CYCLES = 32'd8_000_000,
    parameter logic [31:0] ARR_CYCLES = 32'd2_500_000
) (
    input  logic clk,
    input  logic rst_l,
    input  logic btn,
    input  logic enable,
    output logic action,
    output logic held
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    state_t      state;
    logic [31:0] cnt;
    logic        btn_s;
    logic        btn_q;
    logic        armed;
    logic        press;
    logic        stop;

`ifdef ACTION_REPEAT_SYNC_EN
    logic sync1;
    logic sync2;
    // two-flop synchronizer for the asynchronous button pin
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end
    assign btn_s = sync2;
`else
    assign btn_s = btn;
`endif

    assign press = btn_s & ~btn_q & armed & enable;
    assign stop  = ~btn_s | ~enable;

    // edge history and re-arm: a press only counts after a release seen while enabled
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            btn_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            btn_q <= btn_s;
            armed <= enable & (armed | ~btn_s);
        end
    end

    // DAS/ARR state machine with registered action and held outputs
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state  <= IDLE;
            cnt    <= 32'd0;
            action <= 1'b0;
            held   <= 1'b0;
        end else begin
            action <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 32'd0;
                    if (press) begin
                        action <= 1'b1;
                        held   <= 1'b1;
                        state  <= DELAY;
                    end
                end
                DELAY: begin
                    if (stop) begin
                        cnt   <= 32'd0;
                        held  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == DAS_CYCLES - 32'd1) begin
                        if (ARR_CYCLES != 32'd0) begin
                            action <= 1'b1;
                            cnt    <= 32'd0;
                            state  <= REPEAT;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                REPEAT: begin
                    if (stop) begin
                        cnt   <= 32'd0;
                        held  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == ARR_CYCLES - 32'd1) begin
                        action <= 1'b1;
                        cnt    <= 32'd0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    cnt   <= 32'd0;
                    held  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
